// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 key sequencing path.
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_GAP  = 2'd2
    } ps2_ctrl_state_t;

    typedef struct packed {
        logic make;
        logic rpt;
        logic brk;
    } ps2_ev_t;

    function automatic logic is_prefix(input logic [7:0] b);
        return (b == PS2_EXT) || (b == PS2_BREAK);
    endfunction

endpackage

// File: rtl/ps2_code_decode.sv
// Prefix and held-key decoder; consumes one byte per enabled cycle.
module ps2_code_decode
    import ps2_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       en_i,
    input  logic [7:0] code_i,
    output logic [7:0] key_code_o,
    output logic       key_ext_o,
    output logic       key_down_o,
    output ps2_ev_t    ev_o,
    output logic       make_o
);

    logic       ext_pend_q, ext_pend_d;
    logic       brk_pend_q, brk_pend_d;
    logic [7:0] key_code_q, key_code_d;
    logic       key_ext_q,  key_ext_d;
    logic       key_down_q, key_down_d;
    ps2_ev_t    ev_q,       ev_d;
    logic       match;

    // key_code_q doubles as the held key: it only diverges while key_down_q=0
    assign match = key_down_q
                && (code_i == key_code_q)
                && (ext_pend_q == key_ext_q);

    always_comb begin
        ext_pend_d = ext_pend_q;
        brk_pend_d = brk_pend_q;
        key_code_d = key_code_q;
        key_ext_d  = key_ext_q;
        key_down_d = key_down_q;
        ev_d       = '0;
        if (en_i) begin
            unique case (1'b1)
                (code_i == PS2_EXT): begin
                    ext_pend_d = 1'b1;
                end
                (code_i == PS2_BREAK): begin
                    brk_pend_d = 1'b1;
                end
                default: begin
                    ext_pend_d = 1'b0;
                    brk_pend_d = 1'b0;
                    if (brk_pend_q) begin
                        if (match) begin
                            ev_d.brk   = 1'b1;
                            key_down_d = 1'b0;
                            key_code_d = code_i;
                            key_ext_d  = ext_pend_q;
                        end
                    end else if (match) begin
                        ev_d.rpt = 1'b1;
                    end else begin
                        ev_d.make  = 1'b1;
                        key_down_d = 1'b1;
                        key_code_d = code_i;
                        key_ext_d  = ext_pend_q;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ext_pend_q <= 1'b0;
            brk_pend_q <= 1'b0;
            key_code_q <= 8'h00;
            key_ext_q  <= 1'b0;
            key_down_q <= 1'b0;
            ev_q       <= '0;
        end else begin
            ext_pend_q <= ext_pend_d;
            brk_pend_q <= brk_pend_d;
            key_code_q <= key_code_d;
            key_ext_q  <= key_ext_d;
            key_down_q <= key_down_d;
            ev_q       <= ev_d;
        end
    end

    assign key_code_o = key_code_q;
    assign key_ext_o  = key_ext_q;
    assign key_down_o = key_down_q;
    assign ev_o       = ev_q;
    assign make_o     = ev_d.make;

endmodule

// File: rtl/ps2_key_ctrl.sv
// FIFO drain handshake, press counter and sticky overflow around the decoder.
module ps2_key_ctrl
    import ps2_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ready,
    input  logic [7:0]       data,
    input  logic             overflow,
    output logic             nextdata_n,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic             key_down,
    output logic             ev_make,
    output logic             ev_repeat,
    output logic             ev_break,
    output logic [CNT_W-1:0] press_cnt,
    output logic             ovf_sticky
);

    ps2_ctrl_state_t  state_q, state_d;
    logic [7:0]       byte_q,  byte_d;
    logic             pop_n_q, pop_n_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             ovf_q,   ovf_d;
    logic             dec_en;
    logic             dec_make;
    ps2_ev_t          dec_ev;

    // GAP gives the receiver read pointer a cycle to settle after the pop
    always_comb begin
        state_d = state_q;
        byte_d  = byte_q;
        pop_n_d = 1'b1;
        unique case (state_q)
            ST_IDLE: begin
                if (ready) begin
                    byte_d  = data;
                    pop_n_d = 1'b0;
                    state_d = ST_ACK;
                end
            end
            ST_ACK:  state_d = ST_GAP;
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign dec_en = (state_q == ST_ACK);
    assign cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, dec_make};
    assign ovf_d  = ovf_q | overflow;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            byte_q  <= 8'h00;
            pop_n_q <= 1'b1;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
            pop_n_q <= pop_n_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    ps2_code_decode u_decode (
        .clock      (clock),
        .reset      (reset),
        .en_i       (dec_en),
        .code_i     (byte_q),
        .key_code_o (key_code),
        .key_ext_o  (key_ext),
        .key_down_o (key_down),
        .ev_o       (dec_ev),
        .make_o     (dec_make)
    );

    assign nextdata_n = pop_n_q;
    assign ev_make    = dec_ev.make;
    assign ev_repeat  = dec_ev.rpt;
    assign ev_break   = dec_ev.brk;
    assign press_cnt  = cnt_q;
    assign ovf_sticky = ovf_q;

endmodule
